// File: rtl/dt_pkg.sv
// Shared constants and state encoding for the distance-transform result path.
package dt_pkg;

  localparam int unsigned IMG_W   = 128;
  localparam int unsigned IMG_H   = 128;
  localparam int unsigned IMG_PIX = IMG_W * IMG_H;
  localparam int unsigned WORD_W  = 16;
  localparam int unsigned RES_AW  = 14;
  localparam int unsigned PK_AW   = 10;
  localparam int unsigned CNT_W   = 15;

  typedef enum logic [1:0] {
    RP_IDLE,
    RP_RUN,
    RP_FLUSH,
    RP_DONE
  } rp_state_t;

endpackage

// File: rtl/res_pack_shift.sv
// MSB-first bit assembler: collects WORD_W thresholded pixels into one word
// and keeps a running count of set pixels.
module res_pack_shift #(
  parameter int unsigned WORD_W = 16,
  parameter int unsigned CNT_W  = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_vld,
  input  logic              in_bit,
  output logic              word_cmp,
  output logic [WORD_W-1:0] word,
  output logic [CNT_W-1:0]  cnt
);

  localparam int unsigned IW = $clog2(WORD_W);

  logic [WORD_W-1:0] sh;
  logic [IW-1:0]     idx;

  // The completed word includes the bit arriving this cycle, so the caller
  // can register it straight into its output without an extra stage.
  assign word     = {sh[WORD_W-2:0], in_bit};
  assign word_cmp = in_vld && (idx == IW'(WORD_W - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      sh  <= '0;
      idx <= '0;
      cnt <= '0;
    end else if (clear) begin
      sh  <= '0;
      idx <= '0;
      cnt <= '0;
    end else if (in_vld) begin
      sh  <= word;
      idx <= idx + 1'b1;
      if (in_bit) cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/res_pack.sv
// Reads res RAM sequentially, thresholds each distance byte and writes
// 16-pixel MSB-first packed words; also counts set pixels.
module res_pack
  import dt_pkg::*;
#(
  parameter int unsigned IMG_PIX = dt_pkg::IMG_PIX,
  parameter int unsigned WORD_W  = dt_pkg::WORD_W,
  parameter int unsigned RES_AW  = dt_pkg::RES_AW,
  parameter int unsigned PK_AW   = dt_pkg::PK_AW,
  parameter int unsigned CNT_W   = dt_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        thr,
  output logic              res_rd,
  output logic [RES_AW-1:0] res_addr,
  input  logic [7:0]        res_di,
  output logic              pk_wr,
  output logic [PK_AW-1:0]  pk_addr,
  output logic [WORD_W-1:0] pk_do,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  pix_cnt
);

  rp_state_t         state, state_n;
  logic [7:0]        thr_q;
  logic              rd_q;
  logic [PK_AW-1:0]  wcnt;
  logic              start_acc;
  logic              last_addr;
  logic              in_bit;
  logic              word_cmp;
  logic [WORD_W-1:0] word;

  assign start_acc = start && (state == RP_IDLE || state == RP_DONE);
  assign last_addr = (res_addr == RES_AW'(IMG_PIX - 1));
  assign in_bit    = (res_di >= thr_q);

  always_ff @(posedge clk) begin
    if (!reset) state <= RP_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      RP_IDLE:  if (start) state_n = RP_RUN;
      RP_RUN:   if (last_addr) state_n = RP_FLUSH;
      // Only the final word can be written while flushing.
      RP_FLUSH: if (pk_wr) state_n = RP_DONE;
      RP_DONE:  if (start) state_n = RP_RUN;
      default:  state_n = RP_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      res_rd   <= 1'b0;
      res_addr <= '0;
      pk_wr    <= 1'b0;
      pk_addr  <= '0;
      pk_do    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      thr_q    <= '0;
      rd_q     <= 1'b0;
      wcnt     <= '0;
    end else begin
      busy  <= (state_n == RP_RUN) || (state_n == RP_FLUSH);
      done  <= (state_n == RP_DONE);
      rd_q  <= res_rd;
      pk_wr <= word_cmp;
      if (start_acc) begin
        res_rd   <= 1'b1;
        res_addr <= '0;
        thr_q    <= thr;
        wcnt     <= '0;
      end else if (state == RP_RUN) begin
        if (last_addr) res_rd   <= 1'b0;
        else           res_addr <= res_addr + 1'b1;
      end
      if (word_cmp) begin
        pk_addr <= wcnt;
        pk_do   <= word;
        wcnt    <= wcnt + 1'b1;
      end
    end
  end

  // rd_q marks the cycle in which res_di carries the previously addressed pixel.
  res_pack_shift #(
    .WORD_W (WORD_W),
    .CNT_W  (CNT_W)
  ) u_shift (
    .clk      (clk),
    .reset    (reset),
    .clear    (start_acc),
    .in_vld   (rd_q),
    .in_bit   (in_bit),
    .word_cmp (word_cmp),
    .word     (word),
    .cnt      (pix_cnt)
  );

endmodule

// File: tb/tb_res_pack.sv
// Directed/random bench for res_pack against a pixel-level packing model.
module tb_res_pack;
  import dt_pkg::*;

  localparam int NP = IMG_PIX;
  localparam int NW = IMG_PIX / WORD_W;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  thr;
  logic        res_rd;
  logic [13:0] res_addr;
  logic [7:0]  res_di = '0;
  logic        pk_wr;
  logic [9:0]  pk_addr;
  logic [15:0] pk_do;
  logic        busy;
  logic        done;
  logic [14:0] pix_cnt;

  res_pack dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .thr      (thr),
    .res_rd   (res_rd),
    .res_addr (res_addr),
    .res_di   (res_di),
    .pk_wr    (pk_wr),
    .pk_addr  (pk_addr),
    .pk_do    (pk_do),
    .busy     (busy),
    .done     (done),
    .pix_cnt  (pix_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]  mem  [NP];
  logic [15:0] got  [NW];
  logic [15:0] expw [NW];

  // res RAM model: one-cycle read latency
  always @(posedge clk) if (res_rd) res_di <= mem[res_addr];

  int total = 0;
  int bad   = 0;
  int base  = 0;

  task automatic chk(input string tag, input logic [31:0] g, input logic [31:0] e);
    total++;
    assert (g === e) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, g, e);
    end
  endtask

  task automatic run_pass(input logic [7:0] t, input bit inject, input int abort_at);
    int n, nw, rd_bad, wr_bad, busy_bad, first_wr, last_wr, done_cyc, exp_cnt, stray;
    logic [15:0] w;
    logic        exp_rd;
    logic [13:0] exp_addr;
    exp_cnt = 0;
    for (int wi = 0; wi < NW; wi++) begin
      w = '0;
      for (int k = 0; k < WORD_W; k++)
        if (mem[wi*WORD_W + k] >= t) begin
          w[WORD_W-1-k] = 1'b1;
          exp_cnt++;
        end
      expw[wi] = w;
    end
    nw = 0; rd_bad = 0; wr_bad = 0; busy_bad = 0;
    first_wr = -1; last_wr = -1; done_cyc = -1; n = 0;

    @(negedge clk);
    start = 1'b1; thr = t;
    @(posedge clk);
    #1 start = 1'b0;
    base = cyc;
    for (int i = 0; i < NP + 100; i++) begin
      @(negedge clk);
      n = cyc - base + 1;
      if (n == 1) begin
        chk("cyc1_done", done, 0);
        chk("cyc1_cnt", pix_cnt, 0);
        chk("cyc1_busy", busy, 1);
      end
      exp_rd   = (n <= NP);
      exp_addr = (n <= NP) ? 14'(n - 1) : 14'(NP - 1);
      if (res_rd !== exp_rd || res_addr !== exp_addr) rd_bad++;
      if (pk_wr) begin
        if (nw == 0) first_wr = n;
        last_wr = n;
        if (nw < NW) begin
          got[nw] = pk_do;
          if (pk_addr !== 10'(nw) || pk_do !== expw[nw]) wr_bad++;
        end
        nw++;
      end
      if (done) begin
        done_cyc = n;
        break;
      end
      if (busy !== 1'b1) busy_bad++;
      start = inject && (n == 100 || n == NP + 1);
      thr   = start ? ~t : t;
      if (n == abort_at) break;
    end
    start = 1'b0;
    thr   = t;

    if (abort_at > 0) begin
      chk("abort_reached", n, abort_at);
      reset = 1'b0;
      @(negedge clk);
      chk("abort_rd", res_rd, 0);
      chk("abort_wr", pk_wr, 0);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_cnt", pix_cnt, 0);
      reset = 1'b1;
      stray = 0;
      repeat (40) begin
        @(negedge clk);
        if (pk_wr || busy || done || res_rd) stray++;
      end
      chk("abort_idle", stray, 0);
      return;
    end

    chk("done_cycle", done_cyc, NP + 3);
    chk("busy_at_done", busy, 0);
    chk("first_wr_cycle", first_wr, 18);
    chk("last_wr_cycle", last_wr, NP + 2);
    chk("wr_count", nw, NW);
    chk("wr_data_addr_bad", wr_bad, 0);
    chk("rd_seq_bad", rd_bad, 0);
    chk("busy_bad", busy_bad, 0);
    chk("pix_cnt", pix_cnt, exp_cnt);
    @(negedge clk);
    chk("done_hold", done, 1);
    chk("no_wr_in_done", pk_wr, 0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; thr = '0;
    for (int i = 0; i < NP; i++) mem[i] = 8'($urandom);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_res_rd", res_rd, 0);
    chk("rst_res_addr", res_addr, 0);
    chk("rst_pk_wr", pk_wr, 0);
    chk("rst_pk_addr", pk_addr, 0);
    chk("rst_pk_do", pk_do, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pix_cnt", pix_cnt, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    // random content, random threshold, stray start pulses while busy
    run_pass(8'($urandom_range(1, 254)), 1'b1, 0);

    // threshold 0 sets every pixel; restart from DONE
    run_pass(8'd0, 1'b0, 0);
    chk("thr0_cnt", pix_cnt, NP);
    chk("thr0_word0", got[0], 16'hFFFF);
    chk("thr0_wlast", got[NW-1], 16'hFFFF);

    // value and position boundaries
    for (int i = 0; i < NP; i++) mem[i] = 8'd0;
    mem[0] = 8'd5; mem[15] = 8'd5; mem[17] = 8'd4; mem[NP-1] = 8'hFF;
    run_pass(8'd5, 1'b0, 0);
    chk("b5_word0", got[0], 16'h8001);
    chk("b5_word1", got[1], 16'h0000);
    chk("b5_wlast", got[NW-1], 16'h0001);
    chk("b5_cnt", pix_cnt, 3);

    // abort mid-pass, then a clean pass
    run_pass(8'd4, 1'b0, 5000);
    run_pass(8'd4, 1'b0, 0);
    chk("b4_word1", got[1], 16'h4000);
    chk("b4_cnt", pix_cnt, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
